divisor_prog: RTL
=================

// Module: divisor_prog
// PURPOSE
//   Multi-channel programmable clock/strobe divider; successor of the fixed single-output divider.
//   N_CH independent channels derive slow clocks or single-cycle ticks from the 50 MHz system clock.
//   Consumers are the game-timer, animation and debounce logic.
//   Each channel has a runtime-loadable half-period, a mode (square or pulse) and an enable.
//   Reconfiguration is glitch-free: a new setting takes effect only at the channel's next terminal count.
// PARAMETERS
//   FREQ_IN      50000000                   input clock frequency, Hz
//   FREQ_OUT     5                          reset-default output frequency, Hz
//   N_CH         4                          number of channels, >=1
//   CNT_W        23                         counter / half-period width, bits
//   DEFAULT_HALF FREQ_IN/(2*FREQ_OUT)-1     reset half-period code, must fit CNT_W
//   CH_W         (N_CH>1)?$clog2(N_CH):1    channel-select width
// PORTS
//   clkd      in   1       system clock, 50 MHz, all logic on posedge
//   rst       in   1       synchronous, active-high reset
//   en        in   N_CH    per-channel run enable
//   cfg_we    in   1       config write request
//   cfg_ch    in   CH_W    channel addressed by the write
//   cfg_half  in   CNT_W   new half-period code H; half-period = H+1 cycles
//   cfg_mode  in   1       0 = 50% square, 1 = one-cycle pulse per terminal count
//   cfg_ready out  1       write accepted this cycle if cfg_we=1; = ~pending[cfg_ch]
//   clk_out   out  N_CH    divided outputs, registered
//   tick      out  N_CH    one-cycle strobe on each clk_out 0->1 edge, registered
// BEHAVIOUR
//   Reset (rst=1 at posedge), all channels:
//     - count=0, clk_out=0, tick=0
//     - half=DEFAULT_HALF, mode=0, pending=0, so cfg_ready=1
//     - reset mid-operation discards pending writes and restarts all phases
//   Per channel, en=1:
//     - terminal when count==half: count<=0; otherwise count<=count+1
//     - mode 0: clk_out toggles at terminal; period 2*(H+1) cycles
//     - mode 1: clk_out<=1 at terminal, 0 otherwise; high 1 cycle every H+1 cycles
//     - H=0 in mode 1 holds clk_out at 1 with tick every cycle
//     - tick<=terminal && (mode==1 || clk_out==0)
//     - latency: clk_out/tick change on the posedge after the count==half cycle
//   Per channel, en=0:
//     - count<=0, clk_out<=0, tick<=0
//     - on en 0->1, count restarts from 0: first edge after H+1 cycles
//   Config handshake:
//     - accepted when cfg_we && cfg_ready; writes to a channel with pending=1 are dropped
//     - no change to the pending value; the bench must see cfg_ready=0 for that channel
//     - on accept, cfg_half/cfg_mode latch into shadow[cfg_ch] and pending<=1
//     - commit: at the channel's terminal cycle (en=1) or next cycle if en=0
//     - on commit: half<=shadow.half, mode<=shadow.mode, pending<=0
//     - the terminal cycle itself uses the old half/mode; new values govern the next period
//     - mode switch 0->1 while clk_out=1: clk_out<=1 at that terminal, 0 after
//     - accept and commit on the same channel in one cycle: commit uses old shadow
//     - the new write is then held pending, so no write is lost
//   Boundaries:
//     - count never exceeds half; if half lowered below count by commit, count was 0 (commit at terminal)
//     - cfg_ch>=N_CH: cfg_ready=0, write ignored
//     - channels fully independent; simultaneous terminals all honoured
// TESTING
//   (bench params: FREQ_IN=100, FREQ_OUT=10 -> DEFAULT_HALF=4)
//   1 Reset, en=4'b0001 -> ch0 clk_out rises 5 cycles after rst drop, then toggles every 5 cycles.
//     tick on each rise; ch1..3 stay 0.
//   2 Write ch0 H=1 mode0 mid-period -> cfg_ready(ch0)=0 until ch0 terminal.
//     Then period 4 cycles from next period; no runt pulse.
//   3 Write ch1 H=2 mode1, en[1]=1 -> clk_out[1] one-cycle high every 3 cycles, tick[1] coincident.
//   4 Second write to ch0 while pending -> ignored; committed H equals first write.
//   5 Drop en[0] mid-period, raise 7 cycles later -> clk_out[0]=0 while low.
//     First rise H+1 cycles after en returns.
//   6 Assert rst during pending write on ch2 -> after reset ch2 runs at DEFAULT_HALF, cfg_ready=1.

Source files
------------

// File: rtl/divisor_prog.sv
// Multi-channel programmable clock/strobe divider.
// Each channel counts 0..half, producing a square wave (mode 0) or a one-cycle
// pulse (mode 1) plus a rising-edge tick. Config writes land in a per-channel
// shadow and only take effect at that channel's next terminal count, so a
// reprogram never produces a runt high or low phase.

// One divider channel: counter, output flops and shadow config.
module divisor_prog_ch #(
  parameter int               CNT_W    = 23,
  parameter logic [CNT_W-1:0] RST_HALF = '0
) (
  input  logic             clkd,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,       // write accepted for this channel
  input  logic [CNT_W-1:0] wr_half,
  input  logic             wr_mode,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);
  typedef struct packed {
    logic [CNT_W-1:0] half;
    logic             mode;
  } cfg_t;

  cfg_t             cur, shadow;
  logic [CNT_W-1:0] count;
  logic             term, commit, clk_nxt;

  assign term   = en && (count == cur.half);
  // While disabled there is no phase to protect, so commit right away.
  assign commit = pending && (term || !en);

  // Next output level; the terminal cycle itself is governed by the old mode.
  always_comb begin
    clk_nxt = clk_out;
    if (cur.mode)  clk_nxt = term;
    else if (term) clk_nxt = ~clk_out;
    // Square->pulse switch while high: hold high through the terminal, then
    // the pulse-mode rule drops it the cycle after.
    if (commit && term && !cur.mode && shadow.mode && clk_out) clk_nxt = 1'b1;
  end

  // Counter, outputs and the shadow/commit handshake.
  always_ff @(posedge clkd) begin
    if (rst) begin
      count   <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      cur     <= '{half: RST_HALF, mode: 1'b0};
      shadow  <= '{half: RST_HALF, mode: 1'b0};
      pending <= 1'b0;
    end else begin
      if (en) begin
        count   <= term ? '0 : count + 1'b1;
        clk_out <= clk_nxt;
        tick    <= term && (cur.mode || !clk_out);
      end else begin
        count   <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end
      // Commit reads the shadow before a same-cycle write replaces it.
      if (commit) cur <= shadow;
      if (wr)     shadow <= '{half: wr_half, mode: wr_mode};
      pending <= wr || (pending && !commit);
    end
  end
endmodule

// Top: config decode and channel array.
module divisor_prog #(
  parameter int FREQ_IN      = 50000000,
  parameter int FREQ_OUT     = 5,
  parameter int N_CH         = 4,
  parameter int CNT_W        = 23,
  parameter int DEFAULT_HALF = FREQ_IN / (2 * FREQ_OUT) - 1,
  parameter int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clkd,
  input  logic             rst,
  input  logic [N_CH-1:0]  en,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic             cfg_mode,
  output logic             cfg_ready,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);
  logic [N_CH-1:0] pending, wr;

  // Ready mirrors the addressed channel; out-of-range channels never accept.
  always_comb begin
    cfg_ready = 1'b0;
    wr        = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = ~pending[i];
        wr[i]     = cfg_we && !pending[i];
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    divisor_prog_ch #(
      .CNT_W   (CNT_W),
      .RST_HALF(CNT_W'(DEFAULT_HALF))
    ) u_ch (
      .clkd    (clkd),
      .rst     (rst),
      .en      (en[i]),
      .wr      (wr[i]),
      .wr_half (cfg_half),
      .wr_mode (cfg_mode),
      .pending (pending[i]),
      .clk_out (clk_out[i]),
      .tick    (tick[i])
    );
  end
endmodule
